life_gen_sequencer: RTL and testbench

- Sequences one Game-of-Life generation over a ROWS x COLS board held in an external single-port, row-wide board RAM.
- Shares the RAM port between the VGA display fetch (absolute priority) and its own read/compute/write-back engine.
- Executes run/step/clear commands and keeps a generation counter.
- Sits between the switch/button control logic and the board RAM; replaces the whole-array register update.

---
 rtl/life_gen_sequencer.sv | 171 +++++++++++++++++
 tb/tb_life_gen_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_sequencer.sv
// One Game-of-Life generation over a row-wide single-port board RAM, computed in place
// with a three-row window; the display fetch always wins the RAM port.
module life_gen_sequencer #(
    parameter int ROWS = 24,
    parameter int COLS = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            tick,
    input  logic            step,
    input  logic            clear,
    input  logic            disp_req,
    input  logic [AW-1:0]   disp_row,
    output logic            disp_valid,
    output logic [COLS-1:0] disp_data,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [COLS-1:0] mem_wdata,
    input  logic [COLS-1:0] mem_rdata,
    output logic            busy,
    output logic            overrun,
    output logic [15:0]     gen_count
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE, S_CLR} state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [AW-1:0] PENULT   = AW'(ROWS - 2);

    state_t          state;
    logic [AW-1:0]   rd_row;
    logic [AW-1:0]   wr_row;
    logic [COLS-1:0] prev;
    logic [COLS-1:0] cur;
    logic [COLS-1:0] nxt;
    logic            clear_pend;
    logic [COLS-1:0] new_row;

    // Shifting in zeros makes the off-board neighbours dead.
    function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] p,
                                                 input logic [COLS-1:0] c,
                                                 input logic [COLS-1:0] n);
        logic [COLS-1:0] pl, pr, cl, cr, nl, nr, r;
        logic [3:0]      cnt;
        pl = p << 1;
        pr = p >> 1;
        cl = c << 1;
        cr = c >> 1;
        nl = n << 1;
        nr = n >> 1;
        r  = '0;
        for (int j = 0; j < COLS; j++) begin
            cnt = 4'(pl[j]) + 4'(p[j]) + 4'(pr[j]) + 4'(cl[j]) + 4'(cr[j])
                + 4'(nl[j]) + 4'(n[j]) + 4'(nr[j]);
            r[j] = (cnt == 4'd3) || ((cnt == 4'd2) && c[j]);
        end
        return r;
    endfunction

    assign new_row   = life_row(prev, cur, nxt);
    assign busy      = (state != S_IDLE);
    assign disp_data = disp_valid ? mem_rdata : '0;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp_req) begin
            mem_addr = disp_row;
        end else begin
            case (state)
                S_RD:  mem_addr = rd_row;
                S_WR: begin
                    mem_addr  = wr_row;
                    mem_we    = 1'b1;
                    mem_wdata = new_row;
                end
                S_CLR: begin
                    mem_addr = wr_row;
                    mem_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_row     <= '0;
            wr_row     <= '0;
            prev       <= '0;
            cur        <= '0;
            nxt        <= '0;
            clear_pend <= 1'b0;
            disp_valid <= 1'b0;
            overrun    <= 1'b0;
            gen_count  <= '0;
        end else begin
            disp_valid <= disp_req;
            if (busy && run && tick)
                overrun <= 1'b1;
            if (busy && clear)
                clear_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (clear || clear_pend) begin
                        state      <= S_CLR;
                        wr_row     <= '0;
                        clear_pend <= 1'b0;
                    end else if (step || (run && tick)) begin
                        state  <= S_RD;
                        rd_row <= '0;
                        wr_row <= '0;
                        prev   <= '0;
                    end
                end
                S_RD: begin
                    if (!disp_req)
                        state <= S_CAP;
                end
                S_CAP: begin
                    if (rd_row == '0) begin
                        cur    <= mem_rdata;
                        rd_row <= AW'(1);
                        state  <= S_RD;
                    end else begin
                        nxt   <= mem_rdata;
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    if (!disp_req) begin
                        prev <= cur;
                        cur  <= nxt;
                        if (wr_row == LAST_ROW) begin
                            state <= S_DONE;
                        end else if (wr_row == PENULT) begin
                            // The bottom row has no row below it to fetch.
                            nxt    <= '0;
                            wr_row <= wr_row + AW'(1);
                        end else begin
                            rd_row <= rd_row + AW'(1);
                            wr_row <= wr_row + AW'(1);
                            state  <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    gen_count <= gen_count + 16'd1;
                    state     <= S_IDLE;
                end
                S_CLR: begin
                    if (!disp_req) begin
                        if (wr_row == LAST_ROW) begin
                            gen_count <= '0;
                            state     <= S_IDLE;
                        end else begin
                            wr_row <= wr_row + AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: behavioural board RAM, reference Life model and a
// display-read scoreboard.
module tb_life_gen_sequencer;

    localparam int ROWS = 24;
    localparam int COLS = 32;
    localparam int AW   = 5;
    localparam int GEN_CYCLES = 3 * ROWS + 1;

    logic            clk = 1'b0;
    logic            reset, run, tick, step, clear, disp_req;
    logic [AW-1:0]   disp_row;
    logic            disp_valid, mem_we, busy, overrun;
    logic [COLS-1:0] disp_data, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     gen_count;

    logic [COLS-1:0] ram [2**AW];
    logic [COLS-1:0] img [ROWS];
    logic [COLS-1:0] gold [ROWS];
    logic            load_en;
    int              wr_cnt;

    logic [COLS-1:0] exp_q [$];
    int              n_checks = 0;
    int              n_errors = 0;

    always #5 clk = ~clk;

    life_gen_sequencer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clk(clk), .reset(reset), .run(run), .tick(tick), .step(step), .clear(clear),
        .disp_req(disp_req), .disp_row(disp_row), .disp_valid(disp_valid),
        .disp_data(disp_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .overrun(overrun), .gen_count(gen_count)
    );

    // Single-port RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        if (load_en) begin
            for (int r = 0; r < ROWS; r++)
                ram[r] <= img[r];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (disp_valid) begin
            if (exp_q.size() == 0)
                check("disp_unexpected", 32'd1, 32'd0);
            else
                check("disp_data", disp_data, exp_q.pop_front());
        end
    end

    task automatic gold_step();
        logic [COLS-1:0] nb [ROWS];
        int cnt, rr, cc;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                            if (gold[rr][cc]) cnt++;
                    end
                nb[r][c] = (cnt == 3) || (cnt == 2 && gold[r][c]);
            end
        end
        for (int r = 0; r < ROWS; r++)
            gold[r] = nb[r];
    endtask

    task automatic load_gold();
        for (int r = 0; r < ROWS; r++)
            img[r] = gold[r];
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic c, input logic t);
        step  = s;
        clear = c;
        tick  = t;
        @(negedge clk);
        step  = 1'b0;
        clear = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        disp_req = 1'b0;
        repeat (2) @(negedge clk);
        check("disp_outstanding", exp_q.size(), 0);
    endtask

    task automatic read_board();
        for (int r = 0; r < ROWS; r++) begin
            disp_req = 1'b1;
            disp_row = AW'(r);
            exp_q.push_back(gold[r]);
            @(negedge clk);
        end
        drain();
    endtask

    // Port-needing engine cycles: RD,CAP,RD,CAP, then (WR,RD,CAP) per middle row, WR,WR,DONE.
    function automatic bit needs_port(input int i);
        if (i < 4)              return (i % 2) == 0;
        if (i < 3 * ROWS - 2)   return ((i - 4) % 3) != 2;
        return i < 3 * ROWS;
    endfunction

    function automatic int stalled_len();
        int i = 0, k = 0;
        while (i < GEN_CYCLES) begin
            k++;
            if (!(needs_port(i) && (k % 2 == 0)))
                i++;
        end
        return k;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, w0;
        reset = 1'b1; run = 1'b0; tick = 1'b0; step = 1'b0; clear = 1'b0;
        disp_req = 1'b0; disp_row = '0; load_en = 1'b0; wr_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_gen_count", gen_count, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_disp_valid", disp_valid, 0);
        reset = 1'b0;
        @(negedge clk);

        // Blinker, two generations
        for (int r = 0; r < ROWS; r++) gold[r] = '0;
        for (int r = 5; r <= 7; r++) gold[r] = 32'h0000_0400;
        load_gold();
        gold_step();
        pulse(1'b1, 1'b0, 1'b0);
        count_busy(n);
        check("blinker_busy", n, GEN_CYCLES);
        check("blinker_gc1", gen_count, 1);
        read_board();
        gold_step();
        pulse(1'b1, 1'b0, 1'b0);
        count_busy(n);
        check("blinker2_busy", n, GEN_CYCLES);
        check("blinker_gc2", gen_count, 2);
        read_board();

        // Corner blocks
        for (int r = 0; r < ROWS; r++) gold[r] = '0;
        gold[0] = 32'hC000_0003; gold[1] = 32'hC000_0003;
        gold[ROWS-2] = 32'hC000_0003; gold[ROWS-1] = 32'hC000_0003;
        load_gold();
        gold_step();
        pulse(1'b1, 1'b0, 1'b0);
        count_busy(n);
        check("corner_busy", n, GEN_CYCLES);
        read_board();

        // Display requests on every second cycle during a generation
        for (int r = 0; r < ROWS; r++) gold[r] = $urandom();
        load_gold();
        gold_step();
        pulse(1'b1, 1'b0, 1'b0);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            if (n % 2 == 0) begin
                disp_req = 1'b1;
                disp_row = AW'(n % ROWS);
                exp_q.push_back(ram[n % ROWS]);
            end else begin
                disp_req = 1'b0;
            end
            @(negedge clk);
        end
        drain();
        check("arb_busy", n, stalled_len());
        check("arb_gc", gen_count, 4);
        read_board();

        // Reset in the 30th busy cycle
        for (int r = 0; r < ROWS; r++) gold[r] = '0;
        for (int r = 5; r <= 7; r++) gold[r] = 32'h0000_0400;
        load_gold();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_gen_count", gen_count, 0);
        check("midrst_mem_addr", mem_addr, 0);
        load_gold();
        gold_step();
        pulse(1'b1, 1'b0, 1'b0);
        count_busy(n);
        check("midrst_rerun_busy", n, GEN_CYCLES);
        check("midrst_rerun_gc", gen_count, 1);
        read_board();

        // Run mode
        do_reset();
        run = 1'b1;
        for (int t = 0; t < 5; t++) begin
            pulse(1'b0, 1'b0, 1'b1);
            repeat (99) @(negedge clk);
        end
        check("run_gc5", gen_count, 5);
        check("run_overrun0", overrun, 0);
        for (int t = 0; t < 4; t++) begin
            pulse(1'b0, 1'b0, 1'b1);
            repeat (49) @(negedge clk);
        end
        repeat (100) @(negedge clk);
        check("run_gc7", gen_count, 7);
        check("run_overrun1", overrun, 1);
        pulse(1'b1, 1'b0, 1'b1);
        count_busy(n);
        check("step_tick_busy", n, GEN_CYCLES);
        check("step_tick_gc", gen_count, 8);
        run = 1'b0;
        pulse(1'b1, 1'b1, 1'b0);
        count_busy(n);
        check("clear_step_busy", n, ROWS);
        check("clear_step_gc", gen_count, 0);
        check("overrun_sticky", overrun, 1);
        do_reset();
        check("overrun_cleared", overrun, 0);

        // Clear arriving mid-generation
        for (int r = 0; r < ROWS; r++) gold[r] = $urandom();
        load_gold();
        pulse(1'b1, 1'b0, 1'b0);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            clear = (n == 20);
            @(negedge clk);
        end
        clear = 1'b0;
        check("pend_gen_busy", n, GEN_CYCLES);
        check("pend_gc1", gen_count, 1);
        w0 = wr_cnt;
        @(negedge clk);
        count_busy(n);
        check("pend_clr_busy", n, ROWS);
        check("pend_clr_writes", wr_cnt - w0, ROWS);
        check("pend_gc0", gen_count, 0);
        for (int r = 0; r < ROWS; r++) gold[r] = '0;
        read_board();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
